tx_line_fifo_ctrl: RTL and testbench

Single-clock 1024x32 line FIFO on the MIPI TX path, the transmit-side counterpart of the RX data FIFO. It accepts 32-bit pixel words from the scaler/pixel pipeline and streams them to the MIPI TX packetizer over a valid/ready interface. It marks the first and last word of every line using a programmable line length. Storage is one inferred simple-dual-port RAM (two 18-bit-wide EMB18K halves, `rammode` sdp, no output register) with 1-cycle read latency. A small prefetch stage gives show-ahead output at one word per cycle.

---
 rtl/tx_line_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_tx_line_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_line_fifo_ctrl.sv
// Show-ahead line FIFO for the MIPI TX path: 1024x32 SDP RAM, 2-entry output buffer
// and first/last-word-of-line marking driven by a programmable line length.
module tx_line_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 32,
    parameter int LW_W       = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DW-1:0]         wr_data,
    output logic                  full,
    output logic                  overflow,
    input  logic [LW_W-1:0]       line_words,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_sol,
    output logic                  rd_eol,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(1 << DEPTH_LOG2);

    logic [DW-1:0]         mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         ram_cnt;
    logic                  skid_vld;
    logic [DW-1:0]         skid_data;
    logic [LW_W-1:0]       widx, cur_len;

    logic                  clr, wr_acc, pop, rd_issue, head_load;
    logic [1:0]            occ_after;
    logic [CW-1:0]         count_nxt, ram_cnt_nxt;
    logic [LW_W-1:0]       widx_nxt, len_nxt, len_live;
    logic [DW-1:0]         ram_word;

    assign clr    = !rstn || flush;
    assign wr_acc = wr_en && !full && !clr;
    assign pop    = rd_valid && rd_ready;

    // Counting the pop lets a refill issue in the same cycle, which is what keeps
    // streaming bubble-free with only two buffer entries.
    assign occ_after = 2'(rd_valid) + 2'(skid_vld) - 2'(pop);
    assign rd_issue  = (ram_cnt != '0) && (occ_after < 2'd2);
    assign head_load = pop || (!rd_valid && rd_issue);

    assign count_nxt   = level + CW'(wr_acc) - CW'(pop);
    assign ram_cnt_nxt = ram_cnt + CW'(wr_acc) - CW'(rd_issue);
    assign ram_word    = mem[rptr];

    assign len_live = (line_words == '0) ? LW_W'(1) : line_words;
    assign widx_nxt = !pop ? widx : ((widx == cur_len - LW_W'(1)) ? '0 : widx + LW_W'(1));
    // A new line picks up line_words when its first word becomes the head.
    assign len_nxt  = (head_load && widx_nxt == '0) ? len_live : cur_len;

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_sol    <= 1'b0;
            rd_eol    <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            widx      <= '0;
            cur_len   <= LW_W'(1);
        end else begin
            if (wr_acc)
                wptr <= wptr + DEPTH_LOG2'(1);
            if (wr_en && full)
                overflow <= 1'b1;
            ram_cnt <= ram_cnt_nxt;
            level   <= count_nxt;
            full    <= (count_nxt == DEPTH_V);
            empty   <= (count_nxt == '0);

            if (rd_issue) begin
                rptr <= rptr + DEPTH_LOG2'(1);
                if (!rd_valid || (pop && !skid_vld)) begin
                    rd_valid <= 1'b1;
                    rd_data  <= ram_word;
                end else if (pop) begin
                    rd_data   <= skid_data;
                    skid_data <= ram_word;
                end else begin
                    skid_vld  <= 1'b1;
                    skid_data <= ram_word;
                end
            end else if (pop) begin
                rd_valid <= skid_vld;
                if (skid_vld)
                    rd_data <= skid_data;
                skid_vld <= 1'b0;
            end

            // Markers only move with the head so they hold steady under backpressure.
            if (head_load) begin
                rd_sol <= (widx_nxt == '0);
                rd_eol <= (widx_nxt == len_nxt - LW_W'(1));
            end
            widx    <= widx_nxt;
            cur_len <= len_nxt;
        end
    end
endmodule

// File: tb/tb_tx_line_fifo_ctrl.sv
// Directed bench for tx_line_fifo_ctrl: reset, fill/overflow, streaming wrap,
// line markers, backpressure and flush.
module tb_tx_line_fifo_ctrl;
    localparam int DL = 10, DW = 32, LW_W = 12;

    logic            clk = 1'b0, rstn = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic [LW_W-1:0] line_words = 12'd4;
    logic            full, overflow, rd_valid, rd_sol, rd_eol, empty;
    logic [DW-1:0]   rd_data;
    logic [DL:0]     level;

    int total = 0, bad = 0;

    tx_line_fifo_ctrl #(.DEPTH_LOG2(DL), .DW(DW), .LW_W(LW_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .overflow(overflow),
        .line_words(line_words),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_sol(rd_sol), .rd_eol(rd_eol), .empty(empty), .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic write_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 32'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_lines(input int n, input logic [31:0] base, input logic [15:0] sol_m,
                              input logic [15:0] eol_m, input int change_at,
                              input logic [LW_W-1:0] new_lw);
        int got;
        got = 0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
            if (rd_valid) begin
                chk($sformatf("line_data%0d", got), 64'(rd_data), 64'(base + 32'(got)));
                chk($sformatf("line_sol%0d", got), 64'(rd_sol), 64'(sol_m[got]));
                chk($sformatf("line_eol%0d", got), 64'(rd_eol), 64'(eol_m[got]));
                got++;
                if (got == change_at)
                    line_words = new_lw;
            end
            tick();
        end
        rd_ready = 1'b0;
        chk("line_count", 64'(got), 64'(n));
    endtask

    initial begin
        int got, wi, bubbles, stall_err;
        logic prev_stall, ps, pe;
        logic [DW-1:0] pd;

        // reset state
        repeat (3) tick();
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_sol", 64'(rd_sol), 64'd0);
        chk("rst_eol", 64'(rd_eol), 64'd0);

        // single word: write at edge 0, valid in cycle 2
        rstn = 1'b1; wr_en = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("sw_empty1", 64'(empty), 64'd0);
        chk("sw_level1", 64'(level), 64'd1);
        chk("sw_valid1", 64'(rd_valid), 64'd0);
        tick();
        chk("sw_valid2", 64'(rd_valid), 64'd1);
        chk("sw_data2", 64'(rd_data), 64'hA5A5_0001);
        chk("sw_sol2", 64'(rd_sol), 64'd1);
        chk("sw_eol2", 64'(rd_eol), 64'd0);
        tick();
        chk("sw_empty3", 64'(empty), 64'd1);
        chk("sw_level3", 64'(level), 64'd0);
        chk("sw_valid3", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;
        do_flush();

        // fill to full, then a write while full together with a read
        write_words(1024, 32'd0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'd1024);
        chk("fill_valid", 64'(rd_valid), 64'd1);
        wr_en = 1'b1; wr_data = 32'hBEEF; rd_ready = 1'b1;
        chk("drain_data0", 64'(rd_data), 64'd0);
        tick();
        wr_en = 1'b0;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(level), 64'd1023);
        chk("ovf_full", 64'(full), 64'd0);
        got = 1;
        for (int cyc = 0; cyc < 1200 && got < 1024; cyc++) begin
            if (rd_valid) begin
                chk($sformatf("drain_data%0d", got), 64'(rd_data), 64'(got));
                got++;
            end
            tick();
        end
        chk("drain_count", 64'(got), 64'd1024);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_valid", 64'(rd_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        rd_ready = 1'b0;
        do_flush();
        chk("ovf_flushed", 64'(overflow), 64'd0);

        // streaming across pointer wrap
        rd_ready = 1'b1; got = 0; wi = 0; bubbles = 0;
        for (int cyc = 0; cyc < 3100 && got < 3000; cyc++) begin
            wr_en   = (wi < 3000);
            wr_data = 32'h1000_0000 + 32'(wi);
            if (got > 0 && !rd_valid)
                bubbles++;
            if (rd_valid) begin
                chk($sformatf("stream%0d", got), 64'(rd_data), 64'(32'h1000_0000 + 32'(got)));
                got++;
            end
            tick();
            if (wr_en)
                wi++;
        end
        wr_en = 1'b0; rd_ready = 1'b0;
        chk("stream_count", 64'(got), 64'd3000);
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        tick();
        chk("stream_empty", 64'(empty), 64'd1);
        do_flush();

        // line markers: fixed 4, change 4->2 mid-line, and 0 meaning 1
        line_words = 12'd4;
        write_words(10, 32'h3000_0000);
        tick();
        read_lines(10, 32'h3000_0000, 16'h0111, 16'h0088, -1, 12'd4);
        do_flush();
        write_words(10, 32'h3100_0000);
        tick();
        read_lines(10, 32'h3100_0000, 16'h0151, 16'h02A8, 2, 12'd2);
        do_flush();
        line_words = 12'd0;
        write_words(5, 32'h3200_0000);
        tick();
        read_lines(5, 32'h3200_0000, 16'h001F, 16'h001F, -1, 12'd0);
        do_flush();

        // random backpressure
        line_words = 12'd3; got = 0; wi = 0; stall_err = 0;
        prev_stall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
            rd_ready = ($urandom_range(0, 9) < 3);
            wr_en    = (wi < 200) && (cyc % 8 != 7);
            wr_data  = 32'h2000_0000 + 32'(wi);
            if (prev_stall && (!rd_valid || rd_data !== pd || rd_sol !== ps || rd_eol !== pe))
                stall_err++;
            if (rd_valid && rd_ready) begin
                chk($sformatf("bp_data%0d", got), 64'(rd_data), 64'(32'h2000_0000 + 32'(got)));
                chk($sformatf("bp_sol%0d", got), 64'(rd_sol), 64'(got % 3 == 0));
                chk($sformatf("bp_eol%0d", got), 64'(rd_eol), 64'(got % 3 == 2));
                got++;
            end
            prev_stall = rd_valid && !rd_ready;
            pd = rd_data; ps = rd_sol; pe = rd_eol;
            tick();
            if (wr_en)
                wi++;
        end
        wr_en = 1'b0; rd_ready = 1'b0;
        chk("bp_count", 64'(got), 64'd200);
        chk("bp_stable", 64'(stall_err), 64'd0);
        do_flush();

        // flush mid-stream with widx away from zero
        line_words = 12'd4;
        write_words(10, 32'h4000_0000);
        tick(); tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("fl_pre_valid", 64'(rd_valid), 64'd1);
        chk("fl_pre_sol", 64'(rd_sol), 64'd0);
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'h5555;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("fl_empty", 64'(empty), 64'd1);
        chk("fl_valid", 64'(rd_valid), 64'd0);
        chk("fl_ovf", 64'(overflow), 64'd0);
        chk("fl_level", 64'(level), 64'd0);
        tick(); tick();
        chk("fl_wr_ignored", 64'(rd_valid), 64'd0);
        chk("fl_still_empty", 64'(empty), 64'd1);
        wr_en = 1'b1; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        tick();
        chk("fl_next_valid", 64'(rd_valid), 64'd1);
        chk("fl_next_data", 64'(rd_data), 64'h77);
        chk("fl_next_sol", 64'(rd_sol), 64'd1);
        chk("fl_next_eol", 64'(rd_eol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
